correlate_accum: RTL
====================

CORRELATE_ACCUM -- requirements
Module: correlate_accum

Interface
REQ-001 Parameter TRATE, default 6: number of time-multiplexed slots per frame.
REQ-002 Parameter TBITS, default 3: slot-index width, 2**TBITS >= TRATE.
REQ-003 Parameter ACCUM, default 16: accumulator width per component.
REQ-004 clock  in  1  rising-edge system clock.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 valid_i / first_i / last_i  in  1 each  input beat strobe, frame start, frame end.
REQ-007 ai_i, aq_i, bi_i, bq_i  in  1 each  sign bits of antenna A/B I/Q samples (1 => +1, 0 => -1).
REQ-008 ready_i  in  1  downstream accepts current output word.
REQ-009 valid_o / first_o / last_o  out  1 each  result strobe, slot 0 marker, slot TRATE-1 marker.
REQ-010 slot_o  out  TBITS  slot index of current result.
REQ-011 re_o, im_o  out  ACCUM each  unsigned real/imaginary agreement counts.
REQ-012 busy_o  out  1  high when not IDLE.
REQ-013 overflow_o  out  1  sticky dropped-input flag.

Function
REQ-014 Per beat: re_inc = (ai~^bi) + (aq~^bq); im_inc = (aq~^bi) + (ai^bq); each 0..2, computing agreement counts for A*conj(B).
REQ-015 Register bank of TRATE (re, im) pairs; slot pointer advances by one per accepted beat, wrapping TRATE-1 -> 0.
REQ-016 FSM states IDLE, ACCUM, DRAIN; reset state IDLE.
REQ-017 IDLE: valid_i&first_i clears all slots, writes beat increments into slot 0, pointer := 1 mod TRATE, -> ACCUM; valid_i without first_i ignored, no flag.
REQ-018 ACCUM: valid_i adds increments to bank[pointer]; valid_i&first_i restarts exactly as REQ-017.
REQ-019 ACCUM: valid_i&last_i accumulates that beat then -> DRAIN next cycle; first&last together in IDLE gives a single-beat frame -> DRAIN.
REQ-020 DRAIN: valid_o=1, slot_o=k, re_o/im_o=bank[k], k starts at 0; first_o=(k==0), last_o=(k==TRATE-1).
REQ-021 DRAIN: outputs held stable while ready_i=0; k increments on valid_o&ready_i; handshake at k=TRATE-1 -> IDLE.
REQ-022 Latency: valid_o first asserts the cycle after the last_i beat.
REQ-023 valid_i in DRAIN is dropped and sets overflow_o; overflow_o clears only on an accepted first_i beat in IDLE.
REQ-024 Outputs outside DRAIN: valid_o/first_o/last_o=0, slot_o=0, re_o/im_o=0.
REQ-025 Input beats are accepted every cycle in IDLE/ACCUM; no input back-pressure.

Reset
REQ-026 reset_n=0 at a rising edge: FSM IDLE, pointer 0, k 0, all bank entries 0, overflow_o 0, all outputs per REQ-024, busy_o 0.
REQ-027 Reset mid-ACCUM or mid-DRAIN aborts the frame; no partial results emitted afterwards.

Configuration
REQ-028 Macro CORRELATE_ACCUM_SATURATE_EN defined: accumulation saturates at 2**ACCUM-1 per component.
REQ-029 Macro undefined: accumulation wraps modulo 2**ACCUM.

Verification
REQ-030 Frame of 12 beats, all inputs 1, ready_i=1 -> 6 results, each re=4, im=2, slot 0..5, first_o on slot 0, last_o on slot 5.
REQ-031 Beats with ai=1,aq=0,bi=1,bq=1 -> per-beat re_inc=1, im_inc=0; 18 beats -> re=3, im=0 in every slot.
REQ-032 ready_i low 3 cycles during slot 2 -> slot 2 word held unchanged; total drain 6 handshakes; busy_o low after last.
REQ-033 valid_i during DRAIN -> overflow_o=1, results unchanged; next accepted first_i beat clears it.
REQ-034 ACCUM=4, 10 beats per slot of re_inc=2: with macro re=15; without macro re=4 (20 mod 16).
REQ-035 reset_n=0 for 1 cycle at beat 7 -> no valid_o; new frame afterwards yields correct fresh counts.

Source files
------------

// File: rtl/correlate_accum_if.sv
// Bundle of beat-input and result-output signals for correlate_accum.
// master = the side that produces beats and consumes results,
// slave  = the correlator itself.
interface correlate_accum_if #(
  parameter int TBITS = 3,
  parameter int ACCUM = 16
) ();
  logic             valid_i;
  logic             first_i;
  logic             last_i;
  logic             ai_i;
  logic             aq_i;
  logic             bi_i;
  logic             bq_i;
  logic             ready_i;
  logic             valid_o;
  logic             first_o;
  logic             last_o;
  logic [TBITS-1:0] slot_o;
  logic [ACCUM-1:0] re_o;
  logic [ACCUM-1:0] im_o;
  logic             busy_o;
  logic             overflow_o;

  modport master (
    output valid_i, first_i, last_i, ai_i, aq_i, bi_i, bq_i, ready_i,
    input  valid_o, first_o, last_o, slot_o, re_o, im_o, busy_o, overflow_o
  );

  modport slave (
    input  valid_i, first_i, last_i, ai_i, aq_i, bi_i, bq_i, ready_i,
    output valid_o, first_o, last_o, slot_o, re_o, im_o, busy_o, overflow_o
  );
endinterface

// File: rtl/correlate_accum.sv
// correlate_accum: time-multiplexed sign-bit correlator of A*conj(B).
// Each beat adds I/Q agreement counts into one of TRATE slot accumulators;
// after the frame's last beat the bank is drained one slot per handshake.
// Optional macro CORRELATE_ACCUM_SATURATE_EN: accumulators saturate at
// 2**ACCUM-1 instead of wrapping modulo 2**ACCUM.
module correlate_accum #(
  parameter int TRATE = 6,
  parameter int TBITS = 3,
  parameter int ACCUM = 16
) (
  input logic               clock,
  input logic               reset_n,
  correlate_accum_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_t;

  localparam logic [TBITS-1:0] LAST_SLOT = TBITS'(TRATE - 1);

  state_t           state;
  state_t           state_next;
  logic [ACCUM-1:0] re_bank [TRATE];
  logic [ACCUM-1:0] im_bank [TRATE];
  logic [TBITS-1:0] ptr;
  logic [TBITS-1:0] k;
  logic             overflow;
  logic [1:0]       re_inc;
  logic [1:0]       im_inc;
  logic             restart;
  logic             add_en;

  function automatic logic [TBITS-1:0] next_slot(input logic [TBITS-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + 1'b1;
  endfunction

`ifdef CORRELATE_ACCUM_SATURATE_EN
  function automatic logic [ACCUM-1:0] accum_add(input logic [ACCUM-1:0] acc,
                                                 input logic [1:0]       inc);
    logic [ACCUM:0] sum;
    sum = {1'b0, acc} + (ACCUM + 1)'(inc);
    return sum[ACCUM] ? '1 : sum[ACCUM-1:0];
  endfunction
`else
  function automatic logic [ACCUM-1:0] accum_add(input logic [ACCUM-1:0] acc,
                                                 input logic [1:0]       inc);
    return acc + ACCUM'(inc);
  endfunction
`endif

  // Per-beat agreement counts and beat classification
  always_comb begin
    re_inc  = {1'b0, bus.ai_i ~^ bus.bi_i} + {1'b0, bus.aq_i ~^ bus.bq_i};
    im_inc  = {1'b0, bus.aq_i ~^ bus.bi_i} + {1'b0, bus.ai_i ^ bus.bq_i};
    restart = bus.valid_i && bus.first_i && (state != S_DRAIN);
    add_en  = bus.valid_i && !bus.first_i && (state == S_ACCUM);
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state decode and drain-side output mux
  always_comb begin
    state_next  = state;
    bus.valid_o = 1'b0;
    bus.first_o = 1'b0;
    bus.last_o  = 1'b0;
    bus.slot_o  = '0;
    bus.re_o    = '0;
    bus.im_o    = '0;
    case (state)
      S_IDLE: begin
        if (restart) state_next = bus.last_i ? S_DRAIN : S_ACCUM;
      end
      S_ACCUM: begin
        if (bus.valid_i && bus.last_i) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        bus.valid_o = 1'b1;
        bus.slot_o  = k;
        bus.first_o = (k == '0);
        bus.last_o  = (k == LAST_SLOT);
        for (int j = 0; j < TRATE; j++) begin
          if (k == TBITS'(j)) begin
            bus.re_o = re_bank[j];
            bus.im_o = im_bank[j];
          end
        end
        if (bus.ready_i && (k == LAST_SLOT)) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Slot pointer, drain index and sticky overflow flag
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ptr      <= '0;
      k        <= '0;
      overflow <= 1'b0;
    end else begin
      if (restart)     ptr <= next_slot('0);
      else if (add_en) ptr <= next_slot(ptr);

      if (state != S_DRAIN)  k <= '0;
      else if (bus.ready_i)  k <= next_slot(k);

      if (state == S_DRAIN && bus.valid_i)  overflow <= 1'b1;
      else if (state == S_IDLE && restart)  overflow <= 1'b0;
    end
  end

  // Accumulator bank: cleared and seeded on frame start, else add at pointer
  always_ff @(posedge clock) begin
    for (int j = 0; j < TRATE; j++) begin
      if (!reset_n) begin
        re_bank[j] <= '0;
        im_bank[j] <= '0;
      end else if (restart) begin
        re_bank[j] <= (j == 0) ? ACCUM'(re_inc) : '0;
        im_bank[j] <= (j == 0) ? ACCUM'(im_inc) : '0;
      end else if (add_en && (ptr == TBITS'(j))) begin
        re_bank[j] <= accum_add(re_bank[j], re_inc);
        im_bank[j] <= accum_add(im_bank[j], im_inc);
      end
    end
  end

  assign bus.busy_o     = (state != S_IDLE);
  assign bus.overflow_o = overflow;

endmodule
